// File: rtl/cpu_tick_controller_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cpu_tick_controller_if
// Purpose  : Control/status bundle between a tick controller and its host.
// Revision : 1.0 - initial release
// ============================================================================
interface cpu_tick_controller_if #(
  parameter int DIV_WIDTH   = 16,
  parameter int BURST_WIDTH = 8
);
  logic [DIV_WIDTH-1:0]   divisor_i;
  logic [1:0]             mode_i;
  logic                   step_req_i;
  logic [BURST_WIDTH-1:0] burst_count_i;
  logic                   halt_req_i;
  logic                   tick_o;
  logic                   clock_enable_o;
  logic                   busy_o;
  logic                   done_o;
  logic                   halted_o;
  logic [31:0]            tick_count_o;

  modport master (
    output divisor_i, mode_i, step_req_i, burst_count_i, halt_req_i,
    input  tick_o, clock_enable_o, busy_o, done_o, halted_o, tick_count_o
  );

  modport slave (
    input  divisor_i, mode_i, step_req_i, burst_count_i, halt_req_i,
    output tick_o, clock_enable_o, busy_o, done_o, halted_o, tick_count_o
  );
endinterface
`default_nettype wire

// File: rtl/cpu_tick_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cpu_tick_controller
// Purpose  : Prescaled run / single-step / burst tick generator for a CPU.
//            Define CPU_TICK_TICKCOUNT_EN to implement the 32-bit tick counter.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_tick_controller #(
  parameter int DIV_WIDTH   = 16,
  parameter int BURST_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  cpu_tick_controller_if.slave bus
);

  localparam logic [1:0] MODE_HALT  = 2'b00;
  localparam logic [1:0] MODE_RUN   = 2'b01;
  localparam logic [1:0] MODE_STEP  = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STEP  = 2'd2,
    S_BURST = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [DIV_WIDTH-1:0]   presc_q, presc_d;
  logic [BURST_WIDTH-1:0] remain_q, remain_d;
  logic                   step_prev_q;
  logic                   tick_q, tick_d;
  logic                   done_q, done_d;
  logic                   halted_q, halted_d;
  logic                   busy_q, busy_d;
  logic                   clken_q, clken_d;

  logic terminal;
  logic launch;

  assign terminal = (presc_q >= bus.divisor_i);
  assign launch   = bus.step_req_i & ~step_prev_q & ~bus.halt_req_i & ~halted_q;

  always_comb begin
    state_d  = state_q;
    presc_d  = terminal ? '0 : presc_q + 1'b1;
    remain_d = remain_q;
    tick_d   = 1'b0;
    done_d   = 1'b0;
    halted_d = halted_q;

    if (bus.mode_i == MODE_HALT && !bus.halt_req_i) begin
      halted_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        // Holding the prescaler at zero makes every entry start a full period.
        presc_d = '0;
        if (!halted_q) begin
          if (bus.mode_i == MODE_RUN && !bus.halt_req_i) begin
            state_d = S_RUN;
          end else if (launch && bus.mode_i == MODE_STEP) begin
            state_d  = S_STEP;
            remain_d = BURST_WIDTH'(1);
          end else if (launch && bus.mode_i == MODE_BURST) begin
            if (bus.burst_count_i == '0) begin
              done_d = 1'b1;
            end else begin
              state_d  = S_BURST;
              remain_d = bus.burst_count_i;
            end
          end
        end
      end
      S_RUN: begin
        if (bus.halt_req_i) begin
          state_d  = S_IDLE;
          halted_d = 1'b1;
        end else if (bus.mode_i != MODE_RUN) begin
          state_d = S_IDLE;
        end else begin
          tick_d = terminal;
        end
      end
      S_STEP, S_BURST: begin
        // Completion is flagged one cycle after the last tick has been shown.
        if (bus.halt_req_i) begin
          state_d  = S_IDLE;
          halted_d = 1'b1;
          remain_d = '0;
        end else if (remain_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (terminal) begin
          tick_d   = 1'b1;
          remain_d = remain_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d  = (state_d == S_STEP) || (state_d == S_BURST);
    clken_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      remain_q    <= '0;
      step_prev_q <= 1'b0;
      tick_q      <= 1'b0;
      done_q      <= 1'b0;
      halted_q    <= 1'b0;
      busy_q      <= 1'b0;
      clken_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      remain_q    <= remain_d;
      step_prev_q <= bus.step_req_i;
      tick_q      <= tick_d;
      done_q      <= done_d;
      halted_q    <= halted_d;
      busy_q      <= busy_d;
      clken_q     <= clken_d;
    end
  end

  assign bus.tick_o         = tick_q;
  assign bus.done_o         = done_q;
  assign bus.halted_o       = halted_q;
  assign bus.busy_o         = busy_q;
  assign bus.clock_enable_o = clken_q;

`ifdef CPU_TICK_TICKCOUNT_EN
  logic [31:0] tick_count_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tick_count_q <= '0;
    end else if (tick_q) begin
      tick_count_q <= tick_count_q + 32'd1;
    end
  end

  assign bus.tick_count_o = tick_count_q;
`else
  assign bus.tick_count_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_tick_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cpu_tick_controller
// Purpose  : Randomized scoreboard bench; expected Tick/Done cycles are derived
//            arithmetically from divisor, launch cycle and burst length.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_tick_controller;

  localparam int DIV_W = 16;
  localparam int BW    = 8;

  typedef struct {
    int cyc;
    bit is_done;
  } ev_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_bad;
  int   exp_ticks;
  ev_t  exp_q[$];

  cpu_tick_controller_if #(.DIV_WIDTH(DIV_W), .BURST_WIDTH(BW)) bus ();

  cpu_tick_controller #(.DIV_WIDTH(DIV_W), .BURST_WIDTH(BW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic void push(int c, bit d);
    ev_t e;
    e.cyc     = c;
    e.is_done = d;
    exp_q.push_back(e);
    if (!d) exp_ticks++;
  endfunction

  // Cycle of the i-th tick (0-based) after a launch/entry request in cycle l.
  function automatic int tk(int l, int d, int i);
    return l + 2 + d + (d + 1) * i;
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  function automatic void check_event(bit kind);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL event: unexpected %s at cycle %0d", kind ? "done" : "tick", cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.is_done != kind || e.cyc != cyc) begin
        n_bad++;
        $display("FAIL event: got %s at cycle %0d expected %s at cycle %0d",
                 kind ? "done" : "tick", cyc, e.is_done ? "done" : "tick", e.cyc);
      end
    end
  endfunction

  always @(negedge clk) begin
    if (bus.tick_o === 1'b1) check_event(1'b0);
    if (bus.done_o === 1'b1) check_event(1'b1);
  end

  function automatic logic [1:0] busy_mode();
    int r;
    r = $urandom_range(0, 2);
    return (r == 0) ? 2'b00 : (r == 1) ? 2'b10 : 2'b11;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_mode(int d, int len, bit by_halt);
    int l, x;
    step();
    l = cyc;
    bus.divisor_i = DIV_W'(d);
    bus.mode_i    = 2'b01;
    x = l + len;
    for (int t = l + 2 + d; t <= x; t += d + 1) push(t, 1'b0);
    step();
    chk("run_clken", {31'd0, bus.clock_enable_o}, 32'd1);
    chk("run_busy", {31'd0, bus.busy_o}, 32'd0);
    while (cyc < x) step();
    if (by_halt) bus.halt_req_i = 1'b1;
    else         bus.mode_i     = busy_mode();
    step();
    chk("run_exit_clken", {31'd0, bus.clock_enable_o}, 32'd0);
    if (by_halt) begin
      chk("run_halted_set", {31'd0, bus.halted_o}, 32'd1);
      bus.halt_req_i = 1'b0;
      bus.mode_i     = 2'b00;
      step();
      chk("run_halted_clr", {31'd0, bus.halted_o}, 32'd0);
    end
    bus.mode_i = 2'b00;
    repeat (2) step();
  endtask

  task automatic run_burst(int n_in, int d, bit is_step, int halt_after);
    int l, n, nt, last, dc;
    step();
    l = cyc;
    bus.divisor_i     = DIV_W'(d);
    bus.mode_i        = is_step ? 2'b10 : 2'b11;
    bus.burst_count_i = BW'(n_in);
    bus.step_req_i    = 1'b1;
    n    = is_step ? 1 : n_in;
    nt   = (halt_after > 0) ? halt_after : n;
    for (int i = 0; i < nt; i++) push(tk(l, d, i), 1'b0);
    last = (nt > 0) ? tk(l, d, nt - 1) : l;
    if (halt_after <= 0) push(last + 1, 1'b1);
    step();
    bus.step_req_i    = 1'b0;
    bus.burst_count_i = BW'($urandom);
    chk("launch_busy", {31'd0, bus.busy_o}, {31'd0, n != 0});
    chk("launch_clken", {31'd0, bus.clock_enable_o}, {31'd0, n != 0});
    if (halt_after > 0) begin
      while (cyc < last) begin
        step();
        if (cyc < last) bus.mode_i = busy_mode();
      end
      bus.halt_req_i = 1'b1;
      step();
      bus.halt_req_i = 1'b0;
      bus.mode_i     = 2'b01;
      chk("halt_flag", {31'd0, bus.halted_o}, 32'd1);
      chk("halt_busy", {31'd0, bus.busy_o}, 32'd0);
      repeat (3) step();
      chk("halt_sticky", {31'd0, bus.halted_o}, 32'd1);
      chk("halt_blocks_run", {31'd0, bus.clock_enable_o}, 32'd0);
      bus.mode_i = 2'b00;
      step();
      chk("halt_clear", {31'd0, bus.halted_o}, 32'd0);
    end else begin
      if (n > 0) begin
        // Second request edge while busy must be ignored.
        step();
        bus.step_req_i = 1'b1;
        step();
        bus.step_req_i = 1'b0;
      end
      dc = last + 1;
      while (cyc < dc) begin
        step();
        bus.mode_i = busy_mode();
      end
      chk("done_busy", {31'd0, bus.busy_o}, 32'd0);
    end
    bus.mode_i = 2'b00;
    repeat (2 + $urandom_range(0, 3)) step();
  endtask

  task automatic run_reset_abort(int n, int d, int k);
    int l, r, s;
    step();
    l = cyc;
    bus.divisor_i     = DIV_W'(d);
    bus.mode_i        = 2'b11;
    bus.burst_count_i = BW'(n);
    bus.step_req_i    = 1'b1;
    for (int i = 0; i < k; i++) push(tk(l, d, i), 1'b0);
    r = tk(l, d, k - 1);
    step();
    bus.step_req_i = 1'b0;
    while (cyc < r) step();
    rst_n          = 1'b0;
    bus.step_req_i = 1'b1;
    bus.mode_i     = 2'b10;
    exp_ticks      = 0;
    step();
    chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    chk("rst_clken", {31'd0, bus.clock_enable_o}, 32'd0);
    chk("rst_tickcount", bus.tick_count_o, 32'd0);
    step();
    rst_n = 1'b1;
    s = cyc;
    push(tk(s, d, 0), 1'b0);
    push(tk(s, d, 0) + 1, 1'b1);
    step();
    bus.step_req_i = 1'b0;
    while (cyc < tk(s, d, 0) + 1) step();
    chk("rst_step_done_busy", {31'd0, bus.busy_o}, 32'd0);
    bus.mode_i = 2'b00;
    repeat (3) step();
  endtask

  initial begin
    int kind, d, n;
    n_cmp = 0;
    n_bad = 0;
    exp_ticks = 0;
    rst_n = 1'b0;
    bus.divisor_i     = '0;
    bus.mode_i        = 2'b00;
    bus.step_req_i    = 1'b0;
    bus.burst_count_i = '0;
    bus.halt_req_i    = 1'b0;
    repeat (3) step();
    chk("reset_tick", {31'd0, bus.tick_o}, 32'd0);
    chk("reset_clken", {31'd0, bus.clock_enable_o}, 32'd0);
    chk("reset_busy", {31'd0, bus.busy_o}, 32'd0);
    chk("reset_done", {31'd0, bus.done_o}, 32'd0);
    chk("reset_halted", {31'd0, bus.halted_o}, 32'd0);
    chk("reset_tickcount", bus.tick_count_o, 32'd0);
    rst_n = 1'b1;
    repeat (2) step();

    run_mode(3, 20, 1'b0);
    run_burst(5, 0, 1'b0, 0);
    run_burst(0, 2, 1'b1, 0);
    run_burst(10, 1, 1'b0, 3);
    run_burst(0, 1, 1'b0, 0);
    run_mode(0, 6, 1'b1);

    for (int it = 0; it < 30; it++) begin
      kind = $urandom_range(0, 3);
      d    = $urandom_range(0, 4);
      case (kind)
        0: run_mode(d, $urandom_range(1, 20), 1'($urandom_range(0, 1)));
        1: run_burst(0, d, 1'b1, 0);
        2: run_burst($urandom_range(0, 7), d, 1'b0, 0);
        default: begin
          n = $urandom_range(3, 8);
          run_burst(n, d, 1'b0, $urandom_range(1, n - 1));
        end
      endcase
    end

    run_reset_abort(6, $urandom_range(0, 3), $urandom_range(1, 5));

    repeat (10) step();
    chk("pending_events", exp_q.size(), 32'd0);
`ifdef CPU_TICK_TICKCOUNT_EN
    chk("tick_count", bus.tick_count_o, exp_ticks);
`else
    chk("tick_count", bus.tick_count_o, 32'd0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
